// File: rtl/address_bus_if.sv
// address_bus_if: CPU address in, registered one-hot-per-region chip selects out.
interface address_bus_if;
    logic [15:0] cpu_address;
    logic        SELECT_ram;
    logic        SELECT_vram;
    logic        SELECT_pmf;
    logic        SELECT_pmb;
    logic        SELECT_ntbl;
    logic        SELECT_obm;
    logic        SELECT_firmware;
    logic        SELECT_rom;
    logic        SELECT_vectors;
    logic        SELECT_in_vblank;
    logic        SELECT_clr_vblank_irq;
    logic        SELECT_controller_1;
    logic        SELECT_controller_2;
    logic        SELECT_unmapped;
    modport master (
        output cpu_address,
        input  SELECT_ram, SELECT_vram, SELECT_pmf, SELECT_pmb, SELECT_ntbl, SELECT_obm,
               SELECT_firmware, SELECT_rom, SELECT_vectors, SELECT_in_vblank,
               SELECT_clr_vblank_irq, SELECT_controller_1, SELECT_controller_2, SELECT_unmapped
    );
    modport slave (
        input  cpu_address,
        output SELECT_ram, SELECT_vram, SELECT_pmf, SELECT_pmb, SELECT_ntbl, SELECT_obm,
               SELECT_firmware, SELECT_rom, SELECT_vectors, SELECT_in_vblank,
               SELECT_clr_vblank_irq, SELECT_controller_1, SELECT_controller_2, SELECT_unmapped
    );
endinterface

// File: rtl/address_bus.sv
// address_bus: registered full-width address decoder for the mapache64 CPU bus.
module address_bus (
    input  logic          clk,
    input  logic          rst_n,
    address_bus_if.slave  bus
);
    logic [15:0] a;
    logic [13:0] d, q;
    assign a = bus.cpu_address;
    assign d[0]  = a <= 16'h3FFF;
    assign d[2]  = a >= 16'h4000 && a <= 16'h47FF;
    assign d[3]  = a >= 16'h4800 && a <= 16'h4BFF;
    assign d[4]  = a >= 16'h4C00 && a <= 16'h4EFF;
    assign d[5]  = a >= 16'h4F00 && a <= 16'h4FFF;
    assign d[1]  = |d[5:2];
    assign d[6]  = a >= 16'h5000 && a <= 16'h6FFF;
    assign d[7]  = a[15];
    assign d[8]  = a >= 16'hFFFA;
    assign d[9]  = a == 16'h7000;
    assign d[10] = a == 16'h7001;
    assign d[11] = a == 16'h7002;
    assign d[12] = a == 16'h7003;
    assign d[13] = a >= 16'h7004 && a <= 16'h7FFF;
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) q <= '0;
        else        q <= d;
    assign bus.SELECT_ram            = q[0];
    assign bus.SELECT_vram           = q[1];
    assign bus.SELECT_pmf            = q[2];
    assign bus.SELECT_pmb            = q[3];
    assign bus.SELECT_ntbl           = q[4];
    assign bus.SELECT_obm            = q[5];
    assign bus.SELECT_firmware       = q[6];
    assign bus.SELECT_rom            = q[7];
    assign bus.SELECT_vectors        = q[8];
    assign bus.SELECT_in_vblank      = q[9];
    assign bus.SELECT_clr_vblank_irq = q[10];
    assign bus.SELECT_controller_1   = q[11];
    assign bus.SELECT_controller_2   = q[12];
    assign bus.SELECT_unmapped       = q[13];
endmodule

// File: tb/tb_address_bus.sv
// tb_address_bus: scoreboard bench; expected selects come from a region table.
module tb_address_bus;
    logic clk = 0;
    logic rst_n = 0;
    int checks = 0;
    int failures = 0;
    bit mon_en = 0;
    logic [13:0] q[$];
    address_bus_if bus();
    address_bus dut (.clk(clk), .rst_n(rst_n), .bus(bus));
    always #5 clk = ~clk;
    // bit order: ram vram pmf pmb ntbl obm firmware rom vectors in_vblank clr c1 c2 unmapped
    localparam int LO[14] = '{'h0000, 'h4000, 'h4000, 'h4800, 'h4C00, 'h4F00, 'h5000,
                              'h8000, 'hFFFA, 'h7000, 'h7001, 'h7002, 'h7003, 'h7004};
    localparam int HI[14] = '{'h3FFF, 'h4FFF, 'h47FF, 'h4BFF, 'h4EFF, 'h4FFF, 'h6FFF,
                              'hFFFF, 'hFFFF, 'h7000, 'h7001, 'h7002, 'h7003, 'h7FFF};
    wire [13:0] outs = {bus.SELECT_unmapped, bus.SELECT_controller_2, bus.SELECT_controller_1,
                        bus.SELECT_clr_vblank_irq, bus.SELECT_in_vblank, bus.SELECT_vectors,
                        bus.SELECT_rom, bus.SELECT_firmware, bus.SELECT_obm, bus.SELECT_ntbl,
                        bus.SELECT_pmb, bus.SELECT_pmf, bus.SELECT_vram, bus.SELECT_ram};
    function automatic logic [13:0] model(logic [15:0] a);
        logic [13:0] m = '0;
        for (int i = 0; i < 14; i++) m[i] = int'(a) >= LO[i] && int'(a) <= HI[i];
        return m;
    endfunction
    task automatic check(string name, logic [13:0] got, logic [13:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h expected=%h", name, got, exp);
        end
    endtask
    task automatic issue(logic [15:0] a);
        @(negedge clk);
        bus.cpu_address = a;
        q.push_back(model(a));
    endtask
    task automatic drain();
        int n = 0;
        while (q.size() > 0 && n < 10) begin
            @(negedge clk);
            n++;
        end
        if (q.size() > 0) check("drain_timeout", 14'(q.size()), 14'd0);
    endtask
    // monitor: one decode emerges one edge after each issued address
    initial forever begin
        @(posedge clk);
        #1;
        if (mon_en && q.size() > 0) begin
            logic [13:0] e, o;
            logic [5:0] top;
            logic inv_ok;
            e = q.pop_front();
            o = outs;
            check("decode", o, e);
            top = {o[0], o[1], o[6], o[7], |o[12:9], o[13]};
            inv_ok = $countones(top) == 1 && o[1] == ($countones(o[5:2]) == 1)
                     && (!o[8] || o[7]) && $countones(o[12:9]) <= 1;
            check("invariant", {13'd0, inv_ok}, 14'd1);
        end
    end
    localparam logic [15:0] DIR[21] = '{16'h0000, 16'h3FFF, 16'h4000, 16'h47FF, 16'h4800,
        16'h4C00, 16'h4F00, 16'h4FFF, 16'h5000, 16'h6FFF, 16'h7000, 16'h7001, 16'h7002,
        16'h7003, 16'h7004, 16'h7FFF, 16'h8000, 16'h9000, 16'hFFF9, 16'hFFFA, 16'hFFFF};
    initial begin
        bus.cpu_address = 16'h0000;
        repeat (3) @(posedge clk);
        #1 check("reset_hold", outs, 14'd0);
        @(negedge clk);
        rst_n = 1;
        q.push_back(model(16'h0000));
        mon_en = 1;
        for (int i = 0; i < 21; i++) issue(DIR[i]);
        for (int i = 0; i < 300; i++) issue(16'($urandom));
        for (int i = 0; i < 65536; i++) issue(16'(i));
        drain();
        mon_en = 0;
        @(negedge clk);
        bus.cpu_address = 16'h0000;
        @(posedge clk);
        #1 check("lat_ram", outs, model(16'h0000));
        @(negedge clk);
        bus.cpu_address = 16'h8000;
        #1 check("lat_hold", outs, model(16'h0000));
        @(posedge clk);
        #1 check("lat_rom", outs, model(16'h8000));
        #2 rst_n = 0;
        #1 check("async_reset", outs, 14'd0);
        @(posedge clk);
        #1 check("reset_held", outs, 14'd0);
        @(negedge clk);
        rst_n = 1;
        @(posedge clk);
        #1 check("resume", outs, model(16'h8000));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
